ch0re_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one synchronous single-port memory (one access per cycle, 1-cycle read latency) between the instruction-fetch port (IF) and the load/store port (DM) of the ch0re pipeline. It exists so that imem and dmem can be merged into a single unified memory. It issues grants in the same cycle as the request and routes read data back to the owner one cycle later. DM has default priority. A bounded-wait counter guarantees IF forward progress.

---
 rtl/ch0re_mem_arbiter.sv | 99 +++++++++
 tb/tb_ch0re_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ch0re_mem_arbiter.sv
// Shares one synchronous single-port memory between the IF and DM ports of ch0re.
// DM wins contention by default; IF is promoted after IF_MAX_WAIT consecutive denials.
module ch0re_mem_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 64,
    parameter int IF_MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_dm_req,
    input  logic [DATA_WIDTH/8-1:0] i_dm_wen,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    output logic                    o_dm_gnt,
    output logic                    o_dm_rvalid,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_mem_en,
    output logic [DATA_WIDTH/8-1:0] o_mem_wen,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int CNT_W = (IF_MAX_WAIT > 0) ? $clog2(IF_MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_MAX_WAIT);

    // state    | meaning
    // OWN_NONE | nothing returns on i_mem_rdata next cycle
    // OWN_IF   | next-cycle i_mem_rdata belongs to IF
    // OWN_DM   | next-cycle i_mem_rdata belongs to DM (reads only)
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t                owner;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  if_prio;
    logic [DATA_WIDTH-1:0] if_hold;
    logic [DATA_WIDTH-1:0] dm_hold;

    always_comb begin
        if_prio     = (IF_MAX_WAIT > 0) && (wait_cnt == CNT_MAX);
        o_if_gnt    = i_if_req & (~i_dm_req | if_prio);
        o_dm_gnt    = i_dm_req & ~o_if_gnt;
        o_mem_en    = o_if_gnt | o_dm_gnt;
        o_mem_wen   = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (o_if_gnt) begin
            o_mem_addr = i_if_addr;
        end else if (o_dm_gnt) begin
            o_mem_wen   = i_dm_wen;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            owner    <= OWN_NONE;
            if_hold  <= '0;
            dm_hold  <= '0;
        end else begin
            if (i_if_req && !o_if_gnt) begin
                if (wait_cnt != CNT_MAX)
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (o_if_gnt)
                owner <= OWN_IF;
            else if (o_dm_gnt && (i_dm_wen == '0))
                owner <= OWN_DM;
            else
                owner <= OWN_NONE;

            if (owner == OWN_IF)
                if_hold <= i_mem_rdata;
            if (owner == OWN_DM)
                dm_hold <= i_mem_rdata;
        end
    end

    // Read data is steered straight from the memory while valid, otherwise held.
    assign o_if_rvalid = (owner == OWN_IF);
    assign o_dm_rvalid = (owner == OWN_DM);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_hold;
    assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : dm_hold;

endmodule

// File: tb/tb_ch0re_mem_arbiter.sv
// Self-checking bench for ch0re_mem_arbiter: directed steps plus randomized traffic
// checked against a reference of the arbitration and memory rules.
module tb_ch0re_mem_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 64;
    localparam int BW   = DW / 8;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_req;
    logic [BW-1:0] dm_wen;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic          a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en;
    logic [DW-1:0] a_if_rdata, a_dm_rdata, a_mem_wdata;
    logic [BW-1:0] a_mem_wen;
    logic [AW-1:0] a_mem_addr;

    logic          b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en;
    logic [DW-1:0] b_if_rdata, b_dm_rdata, b_mem_wdata;
    logic [BW-1:0] b_mem_wen;
    logic [AW-1:0] b_mem_addr;

    ch0re_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IF_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(a_if_gnt), .o_if_rvalid(a_if_rvalid), .o_if_rdata(a_if_rdata),
        .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_gnt(a_dm_gnt), .o_dm_rvalid(a_dm_rvalid), .o_dm_rdata(a_dm_rdata),
        .o_mem_en(a_mem_en), .o_mem_wen(a_mem_wen), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Second instance with IF_MAX_WAIT=0 sees the same requests; only its grants/strobes are checked.
    ch0re_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IF_MAX_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(b_if_gnt), .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
        .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_gnt(b_dm_gnt), .o_dm_rvalid(b_dm_rvalid), .o_dm_rdata(b_dm_rdata),
        .o_mem_en(b_mem_en), .o_mem_wen(b_mem_wen), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a < 12'd3) return 64'hA0 + 64'(a);
        if (a == 12'd7) return 64'h0;
        return {20'h5A5A5, a, 20'hC3C3C, a};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r = old;
        for (int i = 0; i < BW; i++)
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // Environment memory attached to the main instance.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    bit            env_wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_wen == '0) begin
                mem_rdata <= env_wr[a_mem_addr] ? env_mem[a_mem_addr] : init_val(a_mem_addr);
            end else begin
                env_mem[a_mem_addr] <= merge(env_wr[a_mem_addr] ? env_mem[a_mem_addr]
                                             : init_val(a_mem_addr), a_mem_wdata, a_mem_wen);
                env_wr[a_mem_addr]  <= 1'b1;
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ref_wr  [0:(1<<AW)-1];
    int            den_a;
    bit            p_if, p_dm, g_if, g_dm;
    logic [DW-1:0] p_if_d, p_dm_d, h_if, h_dm;
    int            n_cmp = 0;
    int            n_err = 0;

    bit            cur_ir, cur_dr;
    logic [AW-1:0] cur_ia, cur_da;
    logic [BW-1:0] cur_dw;
    logic [DW-1:0] cur_dd;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_return();
        chk("if_rvalid", 64'(a_if_rvalid), 64'(p_if));
        if (p_if) h_if = p_if_d;
        chk("if_rdata", a_if_rdata, h_if);
        chk("dm_rvalid", 64'(a_dm_rvalid), 64'(p_dm));
        if (p_dm) h_dm = p_dm_d;
        chk("dm_rdata", a_dm_rdata, h_dm);
    endtask

    task automatic cycle(input bit ir, input logic [AW-1:0] ia, input bit dr,
                         input logic [BW-1:0] dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bit e_if, e_dm, z_if, z_dm;
        @(negedge clk);
        check_return();
        if_req = ir; if_addr = ia; dm_req = dr; dm_wen = dw; dm_addr = da; dm_wdata = dd;
        #1;
        // DM wins unless IF has already been turned away MAXW cycles in a row.
        e_if = ir && (!dr || (MAXW != 0 && den_a >= MAXW));
        e_dm = dr && !e_if;
        z_if = ir && !dr;
        z_dm = dr;
        chk("if_gnt", 64'(a_if_gnt), 64'(e_if));
        chk("dm_gnt", 64'(a_dm_gnt), 64'(e_dm));
        chk("mem_en", 64'(a_mem_en), 64'(e_if || e_dm));
        chk("mem_wen", 64'(a_mem_wen), e_dm ? 64'(dw) : 64'h0);
        chk("mem_addr", 64'(a_mem_addr), e_if ? 64'(ia) : (e_dm ? 64'(da) : 64'h0));
        chk("mem_wdata", a_mem_wdata, e_dm ? dd : 64'h0);
        chk("w0_if_gnt", 64'(b_if_gnt), 64'(z_if));
        chk("w0_dm_gnt", 64'(b_dm_gnt), 64'(z_dm));
        chk("w0_mem_en", 64'(b_mem_en), 64'(z_if || z_dm));
        chk("w0_mem_wen", 64'(b_mem_wen), z_dm ? 64'(dw) : 64'h0);
        chk("w0_mem_addr", 64'(b_mem_addr), z_if ? 64'(ia) : (z_dm ? 64'(da) : 64'h0));
        chk("w0_mem_wdata", b_mem_wdata, z_dm ? dd : 64'h0);
        p_if = e_if;
        if (e_if) p_if_d = ref_rd(ia);
        p_dm = e_dm && (dw == '0);
        if (p_dm) p_dm_d = ref_rd(da);
        if (e_dm && dw != '0) begin
            ref_mem[da] = merge(ref_rd(da), dd, dw);
            ref_wr[da]  = 1'b1;
        end
        den_a = (ir && !e_if) ? den_a + 1 : 0;
        g_if = e_if;
        g_dm = e_dm;
    endtask

    task automatic idle();
        cur_ir = 1'b0;
        cur_dr = 1'b0;
        cycle(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    // A requester that was not granted keeps its whole request unchanged.
    task automatic gen(input int pct_if, input int pct_dm);
        if (!(cur_ir && !g_if)) begin
            cur_ir = ($urandom_range(99) < pct_if);
            cur_ia = AW'($urandom_range(31));
        end
        if (!(cur_dr && !g_dm)) begin
            cur_dr = ($urandom_range(99) < pct_dm);
            cur_da = AW'($urandom_range(31));
            cur_dw = ($urandom_range(1) == 0) ? '0 : BW'($urandom_range(255));
            cur_dd = {$urandom, $urandom};
        end
    endtask

    initial begin
        den_a = 0; p_if = 0; p_dm = 0; g_if = 0; g_dm = 0;
        p_if_d = '0; p_dm_d = '0; h_if = '0; h_dm = '0;
        cur_ir = 0; cur_dr = 0; cur_ia = '0; cur_da = '0; cur_dw = '0; cur_dd = '0;
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_wen = '0; dm_addr = '0; dm_wdata = '0;
        #1;
        chk("rst_if_gnt", 64'(a_if_gnt), 64'h0);
        chk("rst_dm_gnt", 64'(a_dm_gnt), 64'h0);
        chk("rst_mem_en", 64'(a_mem_en), 64'h0);
        chk("rst_mem_addr", 64'(a_mem_addr), 64'h0);
        chk("rst_mem_wdata", a_mem_wdata, 64'h0);
        check_return();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle();
        // IF-only stream from addresses 0..2.
        cycle(1'b1, 12'd0, 1'b0, '0, '0, '0);
        cycle(1'b1, 12'd1, 1'b0, '0, '0, '0);
        cycle(1'b1, 12'd2, 1'b0, '0, '0, '0);
        idle();
        // Full-word write, then read back next cycle.
        cycle(1'b0, '0, 1'b1, 8'hFF, 12'd5, 64'hDEADBEEF_CAFEF00D);
        cycle(1'b0, '0, 1'b1, 8'h00, 12'd5, 64'h0);
        idle();
        // Single-byte write into a zero word.
        cycle(1'b0, '0, 1'b1, 8'h01, 12'd7, 64'hFF);
        cycle(1'b0, '0, 1'b1, 8'h00, 12'd7, 64'h0);
        idle();
        chk("byte_rd_value", a_dm_rdata, 64'h00000000_000000FF);
        // Sustained contention: 4:1 on the main instance, DM-only on the zero-wait one.
        repeat (15) begin
            gen(100, 100);
            cycle(cur_ir, cur_ia, cur_dr, cur_dw, cur_da, cur_dd);
        end
        idle();
        repeat (400) begin
            gen(70, 60);
            cycle(cur_ir, cur_ia, cur_dr, cur_dw, cur_da, cur_dd);
        end
        idle();
        idle();

        // Asynchronous reset between an IF grant and the next clock edge.
        @(negedge clk);
        check_return();
        if_req = 1'b1; if_addr = 12'd1; dm_req = 1'b0; dm_wen = '0; dm_addr = '0; dm_wdata = '0;
        #1;
        chk("rst_mid_if_gnt", 64'(a_if_gnt), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        if_req = 1'b0; if_addr = '0;
        p_if = 0; p_dm = 0; h_if = '0; h_dm = '0; den_a = 0; g_if = 0; g_dm = 0;
        cur_ir = 0; cur_dr = 0;
        repeat (2) begin
            @(negedge clk);
            check_return();
        end
        rst_n = 1'b1;
        cycle(1'b1, 12'd2, 1'b0, '0, '0, '0);
        idle();
        repeat (8) begin
            gen(100, 100);
            cycle(cur_ir, cur_ia, cur_dr, cur_dw, cur_da, cur_dd);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
